// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the RISC-V front-end blocks.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instruction} pairs; flush dominates push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  input  logic                            flush,
  output logic [WIDTH-1:0]                rd_data,
  output logic [cnt_width(DEPTH)-1:0]     count,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= next_ptr(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= next_ptr(rptr_q);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited in-order reads and buffers
// {pc, instruction} pairs for decode; redirects discard all stale data.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned TW = CW + 2;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]   redirect_base;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     fifo_count;
  logic [TW-1:0]     occupancy;
  logic              req_fire;
  logic              resp_legal;
  logic              resp_push;
  logic              resp_drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_head;

  assign redirect_base = redirect_pc & ~XLEN'(3);

  // Every slot is either requested, owed as a drop, or buffered: never over-issue.
  assign occupancy      = TW'(in_flight_q) + TW'(drop_cnt_q) + TW'(fifo_count);
  assign imem_req_valid = rst_n && (occupancy < TW'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_legal = imem_resp_valid && ((in_flight_q != '0) || (drop_cnt_q != '0));
  assign resp_drop  = resp_legal && (drop_cnt_q != '0);
  assign resp_push  = resp_legal && (drop_cnt_q == '0) && !redirect_valid;

  always_comb begin
    pc_d        = pc_q;
    resp_pc_d   = resp_pc_q;
    in_flight_d = in_flight_q;
    drop_cnt_d  = drop_cnt_q;
    if (redirect_valid) begin
      pc_d        = redirect_base;
      resp_pc_d   = redirect_base;
      in_flight_d = '0;
      // Outstanding requests become drops, minus a response retired this cycle.
      drop_cnt_d  = drop_cnt_q + in_flight_q - CW'(resp_legal);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (resp_push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      in_flight_d = in_flight_q + CW'(req_fire) - CW'(resp_push);
      drop_cnt_d  = drop_cnt_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      resp_pc_q   <= resp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_push),
    .push_data ({resp_pc_q, imem_resp_data}),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .rd_data   (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = fifo_head[2*XLEN-1:XLEN];
  assign inst_data  = fifo_head[XLEN-1:0];

  // Simulation-only checks: memory must not return unsolicited data, and the
  // credit scheme must keep the FIFO from overflowing.
  a_no_unsolicited_resp : assert property (
    @(posedge clk) disable iff (!rst_n) imem_resp_valid |-> resp_legal);
  a_no_fifo_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) resp_push |-> (!fifo_full || inst_ready));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: in-order memory model plus a
// stream-level scoreboard of requested and delivered PCs.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit resp_en  = 1'b1;
  int lat_max  = 1;

  typedef struct {
    logic [31:0] addr;
    int          acc;
    int          lat;
    bit          stale;
  } req_t;

  // Model state: requests the memory still owes, and good words not yet consumed.
  req_t        pending[$];
  int          buffered   = 0;
  logic [31:0] exp_req_pc = 32'h0;
  logic [31:0] exp_pop_pc = 32'h0;
  bit          mon_exp_rv;
  bit          mon_pop;
  req_t        mon_ent;

  instruction_fetch #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers the oldest request once its latency has elapsed.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && resp_en && pending.size() > 0 &&
          cyc >= pending[0].acc + pending[0].lat) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memfn(pending[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // Scoreboard: sampled mid-cycle, predicts the transfers at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending.delete();
        buffered   = 0;
        exp_req_pc = 32'h0;
        exp_pop_pc = 32'h0;
      end else begin
        mon_exp_rv = (pending.size() + buffered < 2) && !redirect_valid;
        checks++;
        if (imem_req_valid !== mon_exp_rv) begin
          failures++;
          $display("FAIL credit: imem_req_valid=%0b expected %0b cyc=%0d",
                   imem_req_valid, mon_exp_rv, cyc);
        end
        if (mon_exp_rv) begin
          checks++;
          if (imem_req_addr !== exp_req_pc) begin
            failures++;
            $display("FAIL req_addr: got %h expected %h cyc=%0d", imem_req_addr, exp_req_pc, cyc);
          end
        end
        checks++;
        if (inst_valid !== (buffered > 0)) begin
          failures++;
          $display("FAIL inst_valid: got %0b expected %0b cyc=%0d", inst_valid, buffered > 0, cyc);
        end
        if (buffered > 0) begin
          checks += 2;
          if (inst_pc !== exp_pop_pc) begin
            failures++;
            $display("FAIL inst_pc: got %h expected %h cyc=%0d", inst_pc, exp_pop_pc, cyc);
          end
          if (inst_data !== memfn(exp_pop_pc)) begin
            failures++;
            $display("FAIL inst_data: got %h expected %h cyc=%0d",
                     inst_data, memfn(exp_pop_pc), cyc);
          end
        end
        mon_pop = (buffered > 0) && inst_ready;
        if (imem_resp_valid && pending.size() > 0) begin
          mon_ent = pending.pop_front();
          if (!mon_ent.stale && !redirect_valid) buffered++;
        end
        if (mon_pop) begin
          buffered--;
          exp_pop_pc += 32'd4;
        end
        if (mon_exp_rv && imem_req_ready) begin
          mon_ent.addr  = exp_req_pc;
          mon_ent.acc   = cyc;
          mon_ent.lat   = int'($urandom_range(lat_max, 1));
          mon_ent.stale = 1'b0;
          pending.push_back(mon_ent);
          exp_req_pc += 32'd4;
        end
        if (redirect_valid) begin
          foreach (pending[i]) pending[i].stale = 1'b1;
          buffered   = 0;
          exp_req_pc = redirect_pc & ~32'd3;
          exp_pop_pc = redirect_pc & ~32'd3;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    resp_en        = 1'b1;
    lat_max        = 1;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid: got %0b expected 0", imem_req_valid);
    end
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL reset_inst_valid: got %0b expected 0", inst_valid);
    end
    if (inst_data !== 32'h0) begin
      failures++; $display("FAIL reset_inst_data: got %h expected 0", inst_data);
    end
    if (inst_pc !== 32'h0) begin
      failures++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc);
    end
    repeat (2) next_cycle();
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (imem_req_valid !== 1'b1) begin
      failures++; $display("FAIL release_req_valid: got %0b expected 1", imem_req_valid);
    end
    if (imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL release_req_addr: got %h expected 0", imem_req_addr);
    end
  endtask

  task automatic test_basic_stream();
    logic [31:0] reqs[3];
    logic [31:0] pops[3];
    logic [31:0] datas[3];
    int nreq = 0;
    int npop = 0;
    int resp_cyc = -1;
    int valid_cyc = -1;
    next_cycle();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    #1;
    for (int c = 0; c < 40 && !(nreq == 3 && npop == 3); c++) begin
      if (imem_resp_valid && resp_cyc < 0) resp_cyc = c;
      if (inst_valid && valid_cyc < 0) valid_cyc = c;
      if (imem_req_valid && imem_req_ready && nreq < 3) begin
        reqs[nreq] = imem_req_addr; nreq++;
      end
      if (inst_valid && inst_ready && npop < 3) begin
        pops[npop] = inst_pc; datas[npop] = inst_data; npop++;
      end
      next_cycle();
      #1;
    end
    checks++;
    if (nreq != 3 || npop != 3) begin
      failures++; $display("FAIL basic_timeout: reqs=%0d pops=%0d expected 3/3", nreq, npop);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks += 3;
        if (reqs[i] !== 32'(4 * i)) begin
          failures++; $display("FAIL basic_req%0d: got %h expected %h", i, reqs[i], 32'(4 * i));
        end
        if (pops[i] !== 32'(4 * i)) begin
          failures++; $display("FAIL basic_pc%0d: got %h expected %h", i, pops[i], 32'(4 * i));
        end
        if (datas[i] !== memfn(32'(4 * i))) begin
          failures++;
          $display("FAIL basic_data%0d: got %h expected %h", i, datas[i], memfn(32'(4 * i)));
        end
      end
    end
    checks++;
    if (resp_cyc < 0 || valid_cyc != resp_cyc + 1) begin
      failures++;
      $display("FAIL basic_latency: inst_valid at %0d expected %0d", valid_cyc, resp_cyc + 1);
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    int bad = 0;
    int npop = 0;
    logic [31:0] pops[2];
    do_reset();
    imem_req_ready = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (imem_req_valid && imem_req_ready) nreq++;
      if (inst_valid && inst_pc !== 32'h0) bad++;
      next_cycle();
      #1;
    end
    checks += 4;
    if (nreq != 2) begin
      failures++; $display("FAIL stall_reqs: got %0d expected 2", nreq);
    end
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL stall_req_valid: got %0b expected 0", imem_req_valid);
    end
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      failures++; $display("FAIL stall_head: valid=%0b pc=%h expected 1/0", inst_valid, inst_pc);
    end
    if (bad != 0) begin
      failures++; $display("FAIL stall_stable: %0d unstable cycles expected 0", bad);
    end
    inst_ready = 1'b1;
    for (int c = 0; c < 20 && npop < 2; c++) begin
      if (imem_req_valid && imem_req_ready) nreq++;
      if (inst_valid && inst_ready) begin
        pops[npop] = inst_pc; npop++;
      end
      next_cycle();
      #1;
    end
    checks += 2;
    if (npop != 2 || pops[0] !== 32'h0 || pops[1] !== 32'h4) begin
      failures++;
      $display("FAIL stall_resume: pops=%0d first=%h second=%h expected 0,4", npop, pops[0], pops[1]);
    end
    if (nreq <= 2) begin
      failures++; $display("FAIL stall_req_resume: reqs=%0d expected >2", nreq);
    end
  endtask

  task automatic test_redirect_inflight();
    int nreq = 0;
    int npop = 0;
    logic [31:0] reqs[2];
    logic [31:0] first_pc = 32'hx;
    logic [31:0] first_data = 32'hx;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    resp_en        = 1'b0;
    #1;
    for (int c = 0; c < 10 && nreq < 2; c++) begin
      if (imem_req_valid && imem_req_ready) nreq++;
      next_cycle();
      #1;
    end
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL redir_req_valid: got %0b expected 0", imem_req_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL redir_valid_drop: got %0b expected 0", inst_valid);
    end
    nreq = 0;
    for (int c = 0; c < 30 && !(nreq == 2 && npop == 1); c++) begin
      if (imem_req_valid && imem_req_ready && nreq < 2) begin
        reqs[nreq] = imem_req_addr; nreq++;
      end
      if (inst_valid && inst_ready && npop == 0) begin
        first_pc = inst_pc; first_data = inst_data; npop++;
      end
      next_cycle();
      #1;
    end
    checks += 3;
    if (first_pc !== 32'h100 || first_data !== memfn(32'h100)) begin
      failures++;
      $display("FAIL redir_first_pop: pc=%h data=%h expected 100/%h",
               first_pc, first_data, memfn(32'h100));
    end
    if (nreq < 1 || reqs[0] !== 32'h100) begin
      failures++; $display("FAIL redir_req0: got %h expected 100", reqs[0]);
    end
    if (nreq < 2 || reqs[1] !== 32'h104) begin
      failures++; $display("FAIL redir_req1: got %h expected 104", reqs[1]);
    end
  endtask

  task automatic test_redirect_collide();
    bit hit = 1'b0;
    int npop = 0;
    logic [31:0] first_pc = 32'hx;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      next_cycle();
      if (imem_resp_valid && inst_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        hit            = 1'b1;
      end
    end
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks += 3;
    if (!hit) begin
      failures++; $display("FAIL collide_setup: no resp+pop cycle found expected one");
    end
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL collide_flush: inst_valid=%0b expected 0", inst_valid);
    end
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL collide_restart: valid=%0b addr=%h expected 1/200",
               imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 20 && npop == 0; c++) begin
      if (inst_valid && inst_ready) begin
        first_pc = inst_pc; npop++;
      end
      next_cycle();
      #1;
    end
    checks++;
    if (first_pc !== 32'h200) begin
      failures++; $display("FAIL collide_first_pop: got %h expected 200", first_pc);
    end
  endtask

  task automatic test_wrap();
    int nreq = 0;
    int npop = 0;
    logic [31:0] reqs[2];
    logic [31:0] pops[2];
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    for (int c = 0; c < 30 && !(nreq == 2 && npop == 2); c++) begin
      if (imem_req_valid && imem_req_ready && nreq < 2) begin
        reqs[nreq] = imem_req_addr; nreq++;
      end
      if (inst_valid && inst_ready && npop < 2) begin
        pops[npop] = inst_pc; npop++;
      end
      next_cycle();
      #1;
    end
    checks += 2;
    if (nreq != 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_req: n=%0d %h %h expected FFFFFFFC 00000000", nreq, reqs[0], reqs[1]);
    end
    if (npop != 2 || pops[0] !== 32'hFFFF_FFFC || pops[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pop: n=%0d %h %h expected FFFFFFFC 00000000", npop, pops[0], pops[1]);
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    int npop = 0;
    logic [31:0] first_pc = 32'hx;
    lat_max = 3;
    for (int c = 0; c < 60 && !seen; c++) begin
      next_cycle();
      imem_req_ready = ($urandom_range(1, 0) == 1);
      inst_ready     = ($urandom_range(2, 0) == 0);
      #1;
      if (c >= 5 && inst_valid) seen = 1'b1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (!seen) begin
      failures++; $display("FAIL areset_setup: no valid head found expected one");
    end
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 ||
        inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL areset_outputs: req=%0b valid=%0b data=%h pc=%h expected all 0",
               imem_req_valid, inst_valid, inst_data, inst_pc);
    end
    repeat (2) next_cycle();
    lat_max        = 1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rst_n          = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL areset_restart: valid=%0b addr=%h expected 1/0", imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 20 && npop == 0; c++) begin
      if (inst_valid && inst_ready) begin
        first_pc = inst_pc; npop++;
      end
      next_cycle();
      #1;
    end
    checks++;
    if (first_pc !== 32'h0) begin
      failures++; $display("FAIL areset_first_pop: got %h expected 0", first_pc);
    end
  endtask

  task automatic test_back_to_back();
    int npop = 0;
    lat_max = 3;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      #1;
      if (inst_valid && inst_ready && !redirect_valid) npop++;
    end
    next_cycle();
    redirect_valid = 1'b0;
    checks++;
    if (npop < 20) begin
      failures++; $display("FAIL b2b_progress: pops=%0d expected >=20", npop);
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    test_reset();
    test_basic_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
